// File: rtl/f_register_file_if.sv
//============================================================================
// Module   : f_register_file_if
// Purpose  : Operand, issue/writeback, load and FCSR bundle for f_register_file
// Revision : 1.0
//============================================================================
`default_nettype none

interface f_register_file_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        f_rs1;
    logic [4:0]        f_rs2;
    logic [DATA_W-1:0] f_rs1_data;
    logic [DATA_W-1:0] f_rs2_data;
    logic [2:0]        inst_rm;
    logic [2:0]        frm;
    logic              rm_illegal;
    logic              issue;
    logic [4:0]        issue_rd;
    logic              busy;
    logic              f_ready;
    logic [DATA_W-1:0] FPU_out;
    logic [4:0]        flags;
    logic              load_wen;
    logic [4:0]        load_rd;
    logic [DATA_W-1:0] load_data;
    logic              load_ack;
    logic              csr_wen;
    logic [7:0]        csr_wdata;
    logic [7:0]        fcsr_out;

    modport master (
        output f_rs1, f_rs2, inst_rm, issue, issue_rd, f_ready, FPU_out, flags,
               load_wen, load_rd, load_data, csr_wen, csr_wdata,
        input  f_rs1_data, f_rs2_data, frm, rm_illegal, busy, load_ack, fcsr_out
    );

    modport slave (
        input  f_rs1, f_rs2, inst_rm, issue, issue_rd, f_ready, FPU_out, flags,
               load_wen, load_rd, load_data, csr_wen, csr_wdata,
        output f_rs1_data, f_rs2_data, frm, rm_illegal, busy, load_ack, fcsr_out
    );
endinterface

`default_nettype wire

// File: rtl/f_register_file.sv
//============================================================================
// Module   : f_register_file
// Purpose  : FP register file with FCSR and single-op FPU writeback sequencer
// Revision : 1.0
//============================================================================
`default_nettype none

module f_register_file #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  wire              CLK,
    input  wire              RST,
    f_register_file_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [2:0] C_RM_DYN = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     pend_rd_q, pend_rd_d;
    logic [2:0]        frm_q, frm_d;
    logic [4:0]        fflags_q, fflags_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              w_fpu_wb;
    logic              w_load_ack;
    logic              w_wen;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        w_frm;

    // FPU completion owns the single write port; a colliding load waits.
    assign w_fpu_wb   = (state_q == S_BUSY) && bus.f_ready;
    assign w_load_ack = bus.load_wen && !w_fpu_wb;
    assign w_wen      = w_fpu_wb || w_load_ack;
    assign w_waddr    = w_fpu_wb ? pend_rd_q : bus.load_rd;
    assign w_wdata    = w_fpu_wb ? bus.FPU_out : bus.load_data;

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.issue) begin
                    pend_rd_d = bus.issue_rd;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.f_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frm_d    = frm_q;
        fflags_d = fflags_q;
        if (bus.csr_wen) begin
            frm_d    = bus.csr_wdata[7:5];
            fflags_d = bus.csr_wdata[4:0] | (w_fpu_wb ? bus.flags : 5'b0);
        end else if (w_fpu_wb) begin
            fflags_d = fflags_q | bus.flags;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pend_rd_q <= '0;
            frm_q     <= '0;
            fflags_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
            frm_q     <= frm_d;
            fflags_q  <= fflags_d;
            if (w_wen) begin
                regs_q[w_waddr] <= w_wdata;
            end
        end
    end

    // Write-first bypass so the FPU sees a result in the cycle it commits.
    assign bus.f_rs1_data = (w_wen && (w_waddr == bus.f_rs1)) ? w_wdata : regs_q[bus.f_rs1];
    assign bus.f_rs2_data = (w_wen && (w_waddr == bus.f_rs2)) ? w_wdata : regs_q[bus.f_rs2];

    assign w_frm          = (bus.inst_rm == C_RM_DYN) ? frm_q : bus.inst_rm;
    assign bus.frm        = w_frm;
    assign bus.rm_illegal = (w_frm >= 3'd5);
    assign bus.busy       = (state_q == S_BUSY);
    assign bus.load_ack   = w_load_ack;
    assign bus.fcsr_out   = {frm_q, fflags_q};

endmodule

`default_nettype wire

// File: tb/tb_f_register_file.sv
//============================================================================
// Module   : tb_f_register_file
// Purpose  : Cycle-table and directed-sequence bench for f_register_file
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_f_register_file;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    f_register_file_if #(.DATA_W(32)) bus ();

    f_register_file #(.NREGS(32), .DATA_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [2:0]  rm;
        logic        iss;
        logic [4:0]  ird;
        logic        rdy;
        logic [31:0] fout;
        logic [4:0]  flg;
        logic        lw;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        cw;
        logic [7:0]  cdat;
        logic [31:0] e1, e2;
        logic [2:0]  efrm;
        logic        eill, ebusy, eack;
        logic [7:0]  efcsr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] rm,
        input logic iss, input logic [4:0] ird, input logic rdy,
        input logic [31:0] fout, input logic [4:0] flg,
        input logic lw, input logic [4:0] lrd, input logic [31:0] ldat,
        input logic cw, input logic [7:0] cdat,
        input logic [31:0] e1, input logic [31:0] e2, input logic [2:0] efrm,
        input logic eill, input logic ebusy, input logic eack, input logic [7:0] efcsr);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rm = rm; v.iss = iss; v.ird = ird;
        v.rdy = rdy; v.fout = fout; v.flg = flg; v.lw = lw; v.lrd = lrd;
        v.ldat = ldat; v.cw = cw; v.cdat = cdat; v.e1 = e1; v.e2 = e2;
        v.efrm = efrm; v.eill = eill; v.ebusy = ebusy; v.eack = eack; v.efcsr = efcsr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.f_rs1 = v.rs1; bus.f_rs2 = v.rs2; bus.inst_rm = v.rm;
        bus.issue = v.iss; bus.issue_rd = v.ird;
        bus.f_ready = v.rdy; bus.FPU_out = v.fout; bus.flags = v.flg;
        bus.load_wen = v.lw; bus.load_rd = v.lrd; bus.load_data = v.ldat;
        bus.csr_wen = v.cw; bus.csr_wdata = v.cdat;
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        @(negedge clk);
        drive(v);
        #1;
        tag = $sformatf("v%0d", idx);
        chk({tag, ".rs1_data"},   bus.f_rs1_data,        v.e1);
        chk({tag, ".rs2_data"},   bus.f_rs2_data,        v.e2);
        chk({tag, ".frm"},        {29'd0, bus.frm},      {29'd0, v.efrm});
        chk({tag, ".rm_illegal"}, {31'd0, bus.rm_illegal}, {31'd0, v.eill});
        chk({tag, ".busy"},       {31'd0, bus.busy},     {31'd0, v.ebusy});
        chk({tag, ".load_ack"},   {31'd0, bus.load_ack}, {31'd0, v.eack});
        chk({tag, ".fcsr_out"},   {24'd0, bus.fcsr_out}, {24'd0, v.efcsr});
    endtask

    initial begin
        vec_t idle;
        checks = 0;
        errors = 0;
        idle = mk(0,0,0, 0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0);
        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //        rs1 rs2 rm iss ird rdy fout          flg       lw lrd ldat          cw cdat   e1            e2            frm ill bsy ack fcsr
        vecs.push_back(mk(5, 31, 0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(3, 0,  0, 1, 3,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(3, 3,  0, 0, 0,  1, 32'h3F800000, 5'b00001, 0, 0, 0,            0, 0,     32'h3F800000, 32'h3F800000, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(3, 0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h3F800000, 0,            0, 0, 0, 0, 8'h01));
        vecs.push_back(mk(4, 0,  0, 1, 4,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h01));
        vecs.push_back(mk(4, 0,  0, 0, 0,  1, 32'h40400000, 5'b10000, 0, 0, 0,            0, 0,     32'h40400000, 0,            0, 0, 1, 0, 8'h01));
        vecs.push_back(mk(4, 0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h40400000, 0,            0, 0, 0, 0, 8'h11));
        vecs.push_back(mk(0, 0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            1, 8'h40, 0,            0,            0, 0, 0, 0, 8'h11));
        vecs.push_back(mk(0, 0,  7, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            2, 0, 0, 0, 8'h40));
        vecs.push_back(mk(0, 0,  5, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            5, 1, 0, 0, 8'h40));
        vecs.push_back(mk(0, 0,  4, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            4, 0, 0, 0, 8'h40));
        vecs.push_back(mk(0, 0,  0, 1, 3,  0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h40));
        vecs.push_back(mk(3, 7,  0, 0, 0,  1, 32'h41000000, 0,        1, 7, 32'h40000000, 0, 0,     32'h41000000, 0,            0, 0, 1, 0, 8'h40));
        vecs.push_back(mk(3, 7,  0, 0, 0,  0, 0,            0,        1, 7, 32'h40000000, 0, 0,     32'h41000000, 32'h40000000, 0, 0, 0, 1, 8'h40));
        vecs.push_back(mk(3, 7,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h41000000, 32'h40000000, 0, 0, 0, 0, 8'h40));
        vecs.push_back(mk(0, 0,  0, 1, 10, 0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h40));
        vecs.push_back(mk(0, 0,  0, 1, 11, 0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 1, 0, 8'h40));
        vecs.push_back(mk(10,11, 0, 0, 0,  1, 32'hC0000000, 5'b00100, 0, 0, 0,            0, 0,     32'hC0000000, 0,            0, 0, 1, 0, 8'h40));
        vecs.push_back(mk(10,11, 0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'hC0000000, 0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(10,11, 0, 0, 0,  1, 32'hDEADBEEF, 5'b11111, 0, 0, 0,            0, 0,     32'hC0000000, 0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(10,11, 0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'hC0000000, 0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(0, 0,  0, 1, 12, 0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(12,0,  0, 0, 0,  0, 0,            0,        1, 12,32'h11111111, 0, 0,     32'h11111111, 0,            0, 0, 1, 1, 8'h44));
        vecs.push_back(mk(12,0,  0, 0, 0,  1, 32'h22222222, 0,        0, 0, 0,            0, 0,     32'h22222222, 0,            0, 0, 1, 0, 8'h44));
        vecs.push_back(mk(12,0,  0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h22222222, 0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(0, 0,  0, 1, 13, 0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(13,14, 0, 1, 14, 1, 32'h33333333, 0,        0, 0, 0,            0, 0,     32'h33333333, 0,            0, 0, 1, 0, 8'h44));
        vecs.push_back(mk(13,14, 0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h33333333, 0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(0, 0,  0, 1, 15, 0, 0,            0,        0, 0, 0,            0, 0,     0,            0,            0, 0, 0, 0, 8'h44));
        vecs.push_back(mk(15,0,  0, 0, 0,  1, 32'h44444444, 5'b00010, 0, 0, 0,            1, 8'h61, 32'h44444444, 0,            0, 0, 1, 0, 8'h44));
        vecs.push_back(mk(15,0,  7, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h44444444, 0,            3, 0, 0, 0, 8'h63));
        vecs.push_back(mk(0, 31, 0, 0, 0,  0, 0,            0,        1, 0, 32'h55555555, 0, 0,     32'h55555555, 0,            0, 0, 0, 1, 8'h63));
        vecs.push_back(mk(0, 31, 0, 0, 0,  0, 0,            0,        0, 0, 0,            0, 0,     32'h55555555, 0,            0, 0, 0, 0, 8'h63));

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset while an op is in flight, then a stray f_ready.
        @(negedge clk);
        drive(idle);
        bus.issue = 1'b1; bus.issue_rd = 5'd20;
        #1 chk("rst.pre_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        drive(idle);
        #1 chk("rst.busy_set", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(idle);
        bus.f_ready = 1'b1; bus.FPU_out = 32'h66666666; bus.flags = 5'b11111;
        bus.f_rs1 = 5'd20;
        #1;
        chk("rst.busy_clr",  {31'd0, bus.busy}, 32'd0);
        chk("rst.no_bypass", bus.f_rs1_data, 32'd0);
        @(negedge clk);
        drive(idle);
        bus.f_rs1 = 5'd20; bus.f_rs2 = 5'd3;
        #1;
        chk("rst.reg20",  bus.f_rs1_data, 32'd0);
        chk("rst.reg3",   bus.f_rs2_data, 32'd0);
        chk("rst.fcsr",   {24'd0, bus.fcsr_out}, 32'd0);
        chk("rst.idle",   {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
